// File: rtl/ahb_lite_master_arbiter.sv
// Two-client round-robin front end for a single AHB-Lite master port: one NONSEQ per grant.
// Optional HREADY-stall abort is enabled by defining AHB_ARB_TIMEOUT_EN.
module ahb_lite_master_arbiter
`ifdef AHB_ARB_TIMEOUT_EN
  #(parameter int TIMEOUT_CYC = 16)
`endif
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  REQ,
  input  logic [63:0] REQ_ADDR,
  input  logic [1:0]  REQ_WRITE,
  input  logic [5:0]  REQ_SIZE,
  input  logic [63:0] REQ_WDATA,
  output logic [1:0]  ACK,
  output logic [1:0]  ERR,
  output logic [63:0] RDATA,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int NCL = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

  state_t                  state, state_nxt;
  cmd_t   [NCL-1:0]        cmd;
  logic   [NCL-1:0][31:0]  rdata_q;
  logic   [1:0]            elig;
  logic                    win, owner, last_grant;
  logic                    grant, done, abort;

  for (genvar g = 0; g < NCL; g++) begin : g_cl
    assign cmd[g] = {REQ_ADDR[32*g +: 32], REQ_WRITE[g], REQ_SIZE[3*g +: 3], REQ_WDATA[32*g +: 32]};
  end

  // A client whose ACK is pulsing this cycle is already served; don't re-grant it.
  assign elig   = REQ & ~ACK;
  assign win    = (elig == 2'b11) ? ~last_grant : elig[1];
  assign HTRANS = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign RDATA  = rdata_q;

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 5) ? $clog2(TIMEOUT_CYC + 1) : 5;
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge HCLK) begin
    if (HRESET || HREADY || (state_nxt != state)) wait_cnt <= '0;
    else if (state != S_IDLE)                     wait_cnt <= wait_cnt + 1'b1;
  end

  // Fires on the TIMEOUT_CYC-th consecutive stalled cycle.
  assign abort = (state != S_IDLE) && !HREADY && (wait_cnt == CW'(TIMEOUT_CYC - 1));
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (|elig) begin grant = 1'b1; state_nxt = S_ADDR; end
      S_ADDR: if (HREADY) state_nxt = S_DATA;
      S_DATA: if (HREADY) begin done = 1'b1; state_nxt = S_IDLE; end
      default: state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= S_IDLE;
      HADDR      <= '0;
      HWRITE     <= 1'b0;
      HSIZE      <= '0;
      HWDATA     <= '0;
      ACK        <= '0;
      ERR        <= '0;
      rdata_q    <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      ACK   <= (done || abort) ? (2'b01 << owner) : 2'b00;
      ERR   <= done  ? ({1'b0, HRESP} << owner) :
               abort ? (2'b01 << owner) : 2'b00;
      if (grant) begin
        owner  <= win;
        HADDR  <= cmd[win].addr;
        HWRITE <= cmd[win].write;
        HSIZE  <= cmd[win].size;
        HWDATA <= cmd[win].wdata;
      end
      if (done || abort) last_grant <= owner;
      for (int i = 0; i < NCL; i++)
        if (done && !HWRITE && (owner == 1'(i))) rdata_q[i] <= HRDATA;
    end
  end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Bench for ahb_lite_master_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model (round-robin winner, command capture, response timing).
module tb_ahb_lite_master_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [1:0]  REQ = '0;
  logic [63:0] REQ_ADDR = '0;
  logic [1:0]  REQ_WRITE = '0;
  logic [5:0]  REQ_SIZE = '0;
  logic [63:0] REQ_WDATA = '0;
  logic [1:0]  ACK, ERR;
  logic [63:0] RDATA;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HRDATA = '0;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  ahb_lite_master_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_WRITE(REQ_WRITE),
    .REQ_SIZE(REQ_SIZE), .REQ_WDATA(REQ_WDATA), .ACK(ACK), .ERR(ERR), .RDATA(RDATA),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    HRESET = 1'b1; REQ = '0; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    n_chk++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA, ACK, ERR, RDATA} !== '0) begin
      n_fail++;
      $display("FAIL reset_values got htrans=%b haddr=%h hwrite=%b hsize=%0d hwdata=%h ack=%b err=%b rdata=%h expected all zero",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA, ACK, ERR, RDATA);
    end
    HRESET = 1'b0;
  endtask

  task automatic test_write0();
    REQ_ADDR[31:0] = 32'h5000_0000; REQ_WRITE = 2'b01; REQ_SIZE = 6'b000_010;
    REQ_WDATA[31:0] = 32'h0000_A5A5; REQ = 2'b01; HREADY = 1'b1;
    @(negedge HCLK);
    n_chk++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, ACK} !== {2'b10, 32'h5000_0000, 1'b1, 3'd2, 2'b00}) begin
      n_fail++;
      $display("FAIL wr0_addr_phase got htrans=%b haddr=%h hwrite=%b hsize=%0d ack=%b expected 10/50000000/1/2/00",
               HTRANS, HADDR, HWRITE, HSIZE, ACK);
    end
    @(negedge HCLK);
    n_chk++;
    if ({HTRANS, HWDATA, ACK} !== {2'b00, 32'h0000_A5A5, 2'b00}) begin
      n_fail++;
      $display("FAIL wr0_data_phase got htrans=%b hwdata=%h ack=%b expected 00/0000a5a5/00", HTRANS, HWDATA, ACK);
    end
    @(negedge HCLK);
    n_chk++;
    if ({ACK, ERR, HTRANS} !== {2'b01, 2'b00, 2'b00}) begin
      n_fail++;
      $display("FAIL wr0_ack got ack=%b err=%b htrans=%b expected 01/00/00", ACK, ERR, HTRANS);
    end
    REQ = 2'b00;
    @(negedge HCLK);
    n_chk++;
    if (ACK !== 2'b00) begin
      n_fail++;
      $display("FAIL wr0_ack_single_pulse got ack=%b expected 00", ACK);
    end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_ack;
    logic [31:0] exp_addr;
    HRESET = 1'b1; REQ = 2'b00;
    @(negedge HCLK);
    HRESET = 1'b0;
    REQ_ADDR = {32'h0000_0200, 32'h0000_0100}; REQ_WRITE = 2'b11; REQ_SIZE = 6'b010_010;
    REQ_WDATA = {32'h2222_2222, 32'h1111_1111}; REQ = 2'b11; HREADY = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge HCLK);
      exp_ack = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 1) ? 2'b01 : 2'b10);
      n_chk++;
      if (ACK !== exp_ack) begin
        n_fail++;
        $display("FAIL fair_ack k=%0d got %b expected %b", k, ACK, exp_ack);
      end
      if (k % 3 == 1) begin
        exp_addr = ((k / 3) % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
        n_chk++;
        if ({HTRANS, HADDR} !== {2'b10, exp_addr}) begin
          n_fail++;
          $display("FAIL fair_grant k=%0d got htrans=%b haddr=%h expected 10/%h", k, HTRANS, HADDR, exp_addr);
        end
      end
    end
    REQ = 2'b00;
    @(negedge HCLK);
  endtask

  task automatic test_read_wait();
    REQ_ADDR[31:0] = 32'h0000_0010; REQ_WRITE = 2'b00; REQ = 2'b01; HREADY = 1'b1;
    @(negedge HCLK);
    n_chk++;
    if ({HTRANS, HWRITE} !== {2'b10, 1'b0}) begin
      n_fail++;
      $display("FAIL rd0_addr_phase got htrans=%b hwrite=%b expected 10/0", HTRANS, HWRITE);
    end
    @(negedge HCLK);
    HRDATA = 32'hCAFE_0001;
    @(negedge HCLK);
    n_chk++;
    if ({ACK, RDATA[31:0]} !== {2'b01, 32'hCAFE_0001}) begin
      n_fail++;
      $display("FAIL rd0_complete got ack=%b rdata0=%h expected 01/cafe0001", ACK, RDATA[31:0]);
    end
    REQ_ADDR[63:32] = 32'h0000_0020; REQ = 2'b10; HRDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    n_chk++;
    if ({HTRANS, HADDR} !== {2'b10, 32'h0000_0020}) begin
      n_fail++;
      $display("FAIL rd1_addr_phase got htrans=%b haddr=%h expected 10/00000020", HTRANS, HADDR);
    end
    @(negedge HCLK);
    HREADY = 1'b0; HRESP = 1'b1;
    @(negedge HCLK);
    n_chk++;
    if ({HTRANS, ACK} !== {2'b00, 2'b00}) begin
      n_fail++;
      $display("FAIL rd1_wait got htrans=%b ack=%b expected 00/00", HTRANS, ACK);
    end
    @(negedge HCLK);
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0000_1234;
    @(negedge HCLK);
    n_chk++;
    if ({ACK, ERR, RDATA} !== {2'b10, 2'b00, 32'h0000_1234, 32'hCAFE_0001}) begin
      n_fail++;
      $display("FAIL rd1_complete got ack=%b err=%b rdata=%h expected 10/00/00001234cafe0001", ACK, ERR, RDATA);
    end
    REQ = 2'b00;
    @(negedge HCLK);
  endtask

  task automatic test_error();
    REQ_ADDR[31:0] = 32'h0000_0030; REQ_WDATA[31:0] = 32'h77; REQ_WRITE = 2'b11; REQ = 2'b01; HREADY = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESP = 1'b1;
    @(negedge HCLK);
    n_chk++;
    if ({ACK, ERR} !== {2'b01, 2'b01}) begin
      n_fail++;
      $display("FAIL err_resp got ack=%b err=%b expected 01/01", ACK, ERR);
    end
    HRESP = 1'b0; REQ_ADDR[63:32] = 32'h0000_0040; REQ = 2'b10;
    @(negedge HCLK);
    n_chk++;
    if ({ACK, ERR, HTRANS, HADDR} !== {2'b00, 2'b00, 2'b10, 32'h0000_0040}) begin
      n_fail++;
      $display("FAIL err_next_grant got ack=%b err=%b htrans=%b haddr=%h expected 00/00/10/00000040", ACK, ERR, HTRANS, HADDR);
    end
    @(negedge HCLK);
    @(negedge HCLK);
    n_chk++;
    if ({ACK, ERR} !== {2'b10, 2'b00}) begin
      n_fail++;
      $display("FAIL err_next_ok got ack=%b err=%b expected 10/00", ACK, ERR);
    end
    REQ = 2'b00;
    @(negedge HCLK);
  endtask

  task automatic test_reset_mid();
    // Complete a client-0 transfer first so only a reset can restore client 0 as tie winner.
    REQ_ADDR = {32'h0000_0060, 32'h0000_0050}; REQ_WRITE = 2'b00; REQ = 2'b01; HREADY = 1'b1;
    repeat (3) @(negedge HCLK);
    n_chk++;
    if (ACK !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_pre_ack got %b expected 01", ACK);
    end
    @(negedge HCLK);
    n_chk++;
    if ({HTRANS, ACK} !== {2'b00, 2'b00}) begin
      n_fail++;
      $display("FAIL rst_ack_mask got htrans=%b ack=%b expected 00/00", HTRANS, ACK);
    end
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    n_chk++;
    if ({HTRANS, ACK, ERR, RDATA} !== {2'b00, 2'b00, 2'b00, 64'd0}) begin
      n_fail++;
      $display("FAIL rst_mid_data got htrans=%b ack=%b err=%b rdata=%h expected 00/00/00/0", HTRANS, ACK, ERR, RDATA);
    end
    HRESET = 1'b0; REQ = 2'b11;
    @(negedge HCLK);
    n_chk++;
    if ({HTRANS, HADDR} !== {2'b10, 32'h0000_0050}) begin
      n_fail++;
      $display("FAIL rst_tie_winner got htrans=%b haddr=%h expected 10/00000050", HTRANS, HADDR);
    end
    @(negedge HCLK);
    @(negedge HCLK);
    n_chk++;
    if (ACK !== 2'b01) begin
      n_fail++;
      $display("FAIL rst_tie_ack got %b expected 01", ACK);
    end
    REQ = 2'b10;
    repeat (3) @(negedge HCLK);
    n_chk++;
    if (ACK !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_second_ack got %b expected 10", ACK);
    end
    REQ = 2'b00;
    @(negedge HCLK);
  endtask

  task automatic test_timeout();
    REQ_ADDR[31:0] = 32'h0000_0070; REQ_WRITE = 2'b01; REQ = 2'b01; HREADY = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge HCLK);
      n_chk++;
      if ({HTRANS, ACK} !== {2'b10, 2'b00}) begin
        n_fail++;
        $display("FAIL tmo_stall k=%0d got htrans=%b ack=%b expected 10/00", k, HTRANS, ACK);
      end
    end
    @(negedge HCLK);
`ifdef AHB_ARB_TIMEOUT_EN
    n_chk++;
    if ({HTRANS, ACK, ERR} !== {2'b00, 2'b01, 2'b01}) begin
      n_fail++;
      $display("FAIL tmo_abort got htrans=%b ack=%b err=%b expected 00/01/01", HTRANS, ACK, ERR);
    end
    REQ = 2'b00; HREADY = 1'b1;
`else
    n_chk++;
    if ({HTRANS, ACK} !== {2'b10, 2'b00}) begin
      n_fail++;
      $display("FAIL tmo_no_abort got htrans=%b ack=%b expected 10/00", HTRANS, ACK);
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    n_chk++;
    if ({ACK, ERR} !== {2'b01, 2'b00}) begin
      n_fail++;
      $display("FAIL tmo_late_ack got ack=%b err=%b expected 01/00", ACK, ERR);
    end
    REQ = 2'b00;
`endif
    @(negedge HCLK);
  endtask

  // Random traffic: each client holds a request until acknowledged; the model predicts winner,
  // captured command, phase timing and the response.
  task automatic test_random();
    logic [31:0] ca[2], cd[2];
    logic        cw[2];
    logic [2:0]  cs[2];
    logic [1:0]  pend, elig, eack, eerr, nack, nerr;
    logic [31:0] erd[2];
    logic [31:0] la, lwd, rd;
    logic        lw, rdy, rsp;
    logic [2:0]  ls;
    int          ph, w, lastg, tcnt;
    HRESET = 1'b1; REQ = 2'b00; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    HRESET = 1'b0;
    pend = '0; eack = '0; eerr = '0; ph = 0; w = 0; lastg = 1; tcnt = 0;
    la = '0; lwd = '0; lw = 1'b0; ls = '0;
    for (int i = 0; i < 2; i++) begin
      erd[i] = '0; ca[i] = '0; cd[i] = '0; cw[i] = 1'b0; cs[i] = '0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (eack[i]) pend[i] = 1'($urandom_range(0, 1));
        else if (!pend[i] && $urandom_range(0, 3) == 0) pend[i] = 1'b1;
        else continue;
        if (pend[i]) begin
          ca[i] = $urandom; cd[i] = $urandom; cw[i] = 1'($urandom_range(0, 1)); cs[i] = 3'($urandom_range(0, 7));
        end
      end
      rdy = ($urandom_range(0, 9) < 7); rsp = ($urandom_range(0, 3) == 0); rd = $urandom;
      REQ = pend; REQ_ADDR = {ca[1], ca[0]}; REQ_WDATA = {cd[1], cd[0]};
      REQ_WRITE = {cw[1], cw[0]}; REQ_SIZE = {cs[1], cs[0]};
      HREADY = rdy; HRESP = rsp; HRDATA = rd;

      nack = '0; nerr = '0;
      if (ph == 0) begin
        elig = pend & ~eack;
        if (elig != 2'b00) begin
          w  = (elig == 2'b11) ? 1 - lastg : ((elig == 2'b10) ? 1 : 0);
          la = ca[w]; lw = cw[w]; ls = cs[w]; lwd = cd[w];
          ph = 1; tcnt = 0;
          ca[w] = $urandom; cd[w] = $urandom;   // later command changes must not leak into this transfer
        end
      end else if (rdy) begin
        tcnt = 0;
        if (ph == 1) ph = 2;
        else begin
          nack = 2'b01 << w; nerr = {1'b0, rsp} << w;
          if (!lw) erd[w] = rd;
          lastg = w; ph = 0;
        end
      end else begin
        tcnt++;
`ifdef AHB_ARB_TIMEOUT_EN
        if (tcnt == 16) begin
          nack = 2'b01 << w; nerr = 2'b01 << w; lastg = w; ph = 0; tcnt = 0;
        end
`endif
      end
      eack = nack; eerr = nerr;

      @(negedge HCLK);
      n_chk++;
      if (HTRANS !== ((ph == 1) ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL rnd_htrans c=%0d got %b expected %b", c, HTRANS, (ph == 1) ? 2'b10 : 2'b00);
      end
      if (ph == 1) begin
        n_chk++;
        if ({HADDR, HWRITE, HSIZE} !== {la, lw, ls}) begin
          n_fail++;
          $display("FAIL rnd_cmd c=%0d got haddr=%h hwrite=%b hsize=%0d expected %h/%b/%0d", c, HADDR, HWRITE, HSIZE, la, lw, ls);
        end
      end
      if (ph == 2 && lw) begin
        n_chk++;
        if (HWDATA !== lwd) begin
          n_fail++;
          $display("FAIL rnd_hwdata c=%0d got %h expected %h", c, HWDATA, lwd);
        end
      end
      n_chk++;
      if ({ACK, ERR} !== {eack, eerr}) begin
        n_fail++;
        $display("FAIL rnd_resp c=%0d got ack=%b err=%b expected %b/%b", c, ACK, ERR, eack, eerr);
      end
      n_chk++;
      if (RDATA !== {erd[1], erd[0]}) begin
        n_fail++;
        $display("FAIL rnd_rdata c=%0d got %h expected %h", c, RDATA, {erd[1], erd[0]});
      end
    end
    REQ = 2'b00;
  endtask

  initial begin
    test_reset();
    test_write0();
    test_fairness();
    test_read_wait();
    test_error();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
